// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for a picorv32-style native
// memory bus. Master 0 (CPU) and master 1 (loader/DMA) share one downstream port.
// Each grant covers exactly one transaction, followed by one idle arbitration cycle.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   m0_* / m1_*              master side: valid, instr, addr, wdata, wstrb in; ready, rdata out
//   s_*                      downstream side: valid, instr, addr, wdata, wstrb out; ready, rdata in
//   grant                    one-hot current owner, 2'b00 when idle
//   timeout_err              one-cycle pulse when a downstream access is abandoned
//
// Optional feature: define MEMARB_TIMEOUT_EN to build a wait counter that completes
// a stalled access with ERR_DATA after TIMEOUT_CYCLES busy cycles.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last;       // master that owned the bus most recently
  logic            last_nxt;
  logic            rsp_ready;  // completion strobe routed to the owner
  logic [DW-1:0]   rsp_rdata;

  // Reject out-of-range timeout configurations at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || $bits(ERR_DATA) != DW) begin : g_bad_cfg
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned CW = 16;

  logic [CW-1:0] wait_cnt;
  logic          tmo_hit;

  assign tmo_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Busy-cycle counter; zero whenever the access starts or ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state != IDLE && state_nxt != IDLE) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // State and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration, bus steering and completion routing.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    grant       = 2'b00;
    timeout_err = 1'b0;
    s_valid     = 1'b0;
    s_instr     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    rsp_ready   = 1'b0;
    rsp_rdata   = '0;

    case (state)
      IDLE: begin
        // Both requesting: the master that did not go last wins.
        if (m0_valid && (!m1_valid || last)) begin
          state_nxt = BUSY0;
        end else if (m1_valid) begin
          state_nxt = BUSY1;
        end
      end

      BUSY0, BUSY1: begin
        if (state == BUSY1) begin
          grant   = 2'b10;
          s_valid = m1_valid;
          s_instr = m1_instr;
          s_addr  = m1_addr;
          s_wdata = m1_wdata;
          s_wstrb = m1_wstrb;
        end else begin
          grant   = 2'b01;
          s_valid = m0_valid;
          s_instr = m0_instr;
          s_addr  = m0_addr;
          s_wdata = m0_wdata;
          s_wstrb = m0_wstrb;
        end

        rsp_ready = s_ready;
        rsp_rdata = s_rdata;

        if (s_ready) begin
          state_nxt = IDLE;
          last_nxt  = (state == BUSY1);
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (tmo_hit) begin
          // Abandon the access: answer the master ourselves and withdraw the request.
          rsp_ready   = 1'b1;
          rsp_rdata   = ERR_DATA;
          s_valid     = 1'b0;
          timeout_err = 1'b1;
          state_nxt   = IDLE;
          last_nxt    = (state == BUSY1);
        end
`endif

        if (state == BUSY1) begin
          m1_ready = rsp_ready;
          m1_rdata = rsp_rdata;
        end else begin
          m0_ready = rsp_ready;
          m0_rdata = rsp_rdata;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter.
// Directed table of single transactions, round-robin and reset sequences,
// timeout (or no-timeout) sequence, and a randomized run against a
// transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_instr   (m0_instr),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_instr   (m1_instr),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_instr    (s_instr),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int mlast = 1;      // reference model: master that went last
  int order[$];       // owners in completion order (random engine)

  typedef struct {
    logic        who;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input logic who);
    return who ? m1_ready : m0_ready;
  endfunction

  function automatic logic [31:0] rdat(input logic who);
    return who ? m1_rdata : m0_rdata;
  endfunction

  task automatic drive_m(input logic who, input logic v, input logic ins,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (who) begin
      m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = d; m1_wstrb = st;
    end else begin
      m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = d; m0_wstrb = st;
    end
  endtask

  task automatic apply_reset();
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    s_ready = 1'b0;
    s_rdata = 32'h5A5A_A5A5;
    resetn  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    mlast  = 1;
  endtask

  // One isolated transaction from IDLE with a fixed slave latency.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    drive_m(v.who, 1'b1, v.instr, v.addr, v.wdata, v.wstrb);
    s_ready = 1'b0;
    s_rdata = 32'h0BAD_0000;
    #1;
    chk("vec_arb_grant", 32'(grant), 32'd0);
    chk("vec_arb_s_valid", 32'(s_valid), 32'd0);
    chk("vec_arb_ready", 32'(rdy(v.who)), 32'd0);
    @(negedge clk);
    #1;
    chk("vec_grant", 32'(grant), 32'(v.exp_grant));
    chk("vec_s_valid", 32'(s_valid), 32'd1);
    chk("vec_s_addr", s_addr, v.addr);
    chk("vec_s_wdata", s_wdata, v.wdata);
    chk("vec_s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
    chk("vec_s_instr", 32'(s_instr), 32'(v.instr));
    for (int i = 0; i < v.lat; i++) begin
      chk("vec_wait_ready", 32'(rdy(v.who)), 32'd0);
      chk("vec_wait_other", 32'(rdy(~v.who)), 32'd0);
      @(negedge clk);
      #1;
    end
    s_ready = 1'b1;
    s_rdata = v.rdata;
    #1;
    chk("vec_ready", 32'(rdy(v.who)), 32'd1);
    chk("vec_rdata", rdat(v.who), v.rdata);
    chk("vec_other_ready", 32'(rdy(~v.who)), 32'd0);
    @(negedge clk);
    s_ready = 1'b0;
    s_rdata = 32'hFFFF_0000;
    drive_m(v.who, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("vec_after_grant", 32'(grant), 32'd0);
    chk("vec_after_s_valid", 32'(s_valid), 32'd0);
    chk("vec_after_s_addr", s_addr, 32'd0);
    chk("vec_after_rdata", rdat(v.who), 32'd0);
  endtask

  // Random traffic from both masters; every cycle is compared to a
  // transaction-level model of who should own the bus.
  task automatic run_random(input int n0, input int n1, input int gap_max, input int lat_max,
                            output int got0, output int got1);
    int          rem[2];
    bit          act[2];
    int          gapc[2];
    logic [31:0] ra[2], rd[2];
    logic [3:0]  rs[2];
    logic        ri[2];
    int          own;
    int          scnt, slat;
    bit          finished;
    logic [1:0]  eg;
    rem[0] = n0; rem[1] = n1;
    act[0] = 0;  act[1] = 0;
    gapc[0] = 0; gapc[1] = 0;
    got0 = 0; got1 = 0;
    own = -1; scnt = 0; slat = $urandom_range(0, lat_max);
    finished = 0;
    order.delete();
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && rem[m] > 0) begin
          if (gapc[m] > 0) gapc[m]--;
          else begin
            act[m] = 1;
            ra[m] = $urandom; rd[m] = $urandom;
            rs[m] = 4'($urandom); ri[m] = 1'($urandom);
          end
        end
        if (act[m]) drive_m(m[0], 1'b1, ri[m], ra[m], rd[m], rs[m]);
        else drive_m(m[0], 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      s_rdata = $urandom;
      s_ready = 1'b0;
      #1;
      if (s_valid) begin
        if (scnt >= slat) s_ready = 1'b1;
        else scnt++;
      end
      #1;
      eg = (own < 0) ? 2'b00 : (own == 0 ? 2'b01 : 2'b10);
      chk("rnd_grant", 32'(grant), 32'(eg));
      chk("rnd_s_valid", 32'(s_valid), (own >= 0) ? 32'd1 : 32'd0);
      chk("rnd_s_addr", s_addr, (own >= 0) ? ra[own] : 32'd0);
      chk("rnd_s_wdata", s_wdata, (own >= 0) ? rd[own] : 32'd0);
      chk("rnd_s_wstrb", 32'(s_wstrb), (own >= 0) ? 32'(rs[own]) : 32'd0);
      chk("rnd_s_instr", 32'(s_instr), (own >= 0) ? 32'(ri[own]) : 32'd0);
      chk("rnd_m0_ready", 32'(m0_ready), (own == 0 && s_ready) ? 32'd1 : 32'd0);
      chk("rnd_m1_ready", 32'(m1_ready), (own == 1 && s_ready) ? 32'd1 : 32'd0);
      chk("rnd_m0_rdata", m0_rdata, (own == 0) ? s_rdata : 32'd0);
      chk("rnd_m1_rdata", m1_rdata, (own == 1) ? s_rdata : 32'd0);
      chk("rnd_timeout", 32'(timeout_err), 32'd0);
      if (own >= 0 && s_ready) begin
        if (own == 0) got0++; else got1++;
        order.push_back(own);
        act[own]  = 0;
        rem[own]--;
        gapc[own] = $urandom_range(0, gap_max);
        mlast     = own;
        own       = -1;
        scnt      = 0;
        slat      = $urandom_range(0, lat_max);
      end else if (own < 0) begin
        if (act[0] && act[1]) own = 1 - mlast;
        else if (act[0]) own = 0;
        else if (act[1]) own = 1;
      end
      if (rem[0] == 0 && rem[1] == 0 && !act[0] && !act[1] && own < 0) finished = 1;
    end
    chk("rnd_finished_in_budget", 32'(finished), 32'd1);
    @(negedge clk);
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    s_ready = 1'b0;
  endtask

  initial begin
    int g0, g1;
    bit saw_rdy, saw_to, grant_ok;

    vecs[0] = '{who: 1'b0, instr: 1'b0, addr: 32'h0000_0100, wdata: 32'h0,
                wstrb: 4'b0000, lat: 2, rdata: 32'h1234_5678, exp_grant: 2'b01};
    vecs[1] = '{who: 1'b1, instr: 1'b0, addr: 32'h2000_0000, wdata: 32'hAABB_CCDD,
                wstrb: 4'b0010, lat: 0, rdata: 32'h0, exp_grant: 2'b10};
    vecs[2] = '{who: 1'b0, instr: 1'b0, addr: 32'h1000_0004, wdata: 32'hCAFE_F00D,
                wstrb: 4'b1111, lat: 1, rdata: 32'h0000_0001, exp_grant: 2'b01};
    vecs[3] = '{who: 1'b1, instr: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h0,
                wstrb: 4'b0000, lat: 3, rdata: 32'h8765_4321, exp_grant: 2'b10};
    vecs[4] = '{who: 1'b0, instr: 1'b1, addr: 32'h0000_0000, wdata: 32'h0,
                wstrb: 4'b0000, lat: 0, rdata: 32'hFFFF_FFFF, exp_grant: 2'b01};

    apply_reset();
    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // Both masters request continuously after reset: strict alternation from m0.
    apply_reset();
    run_random(4, 4, 0, 3, g0, g1);
    chk("rr_m0_count", 32'(g0), 32'd4);
    chk("rr_m1_count", 32'(g1), 32'd4);
    chk("rr_order_len", 32'(order.size()), 32'd8);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % 2));

    // Reset while BUSY1 waits; m0 pending through reset must win afterwards.
    apply_reset();
    @(negedge clk);
    drive_m(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h1111_2222, 4'b0000);
    @(negedge clk);
    #1;
    chk("mrst_grant_busy1", 32'(grant), 32'd2);
    drive_m(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'b0000);
    s_rdata = 32'h7777_7777;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_s_valid", 32'(s_valid), 32'd0);
    chk("mrst_s_addr", s_addr, 32'd0);
    chk("mrst_m1_ready", 32'(m1_ready), 32'd0);
    chk("mrst_m1_rdata", m1_rdata, 32'd0);
    chk("mrst_m0_ready", 32'(m0_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("mrst_release_grant", 32'(grant), 32'd0);
    @(negedge clk);
    #1;
    chk("mrst_m0_first", 32'(grant), 32'd1);
    chk("mrst_m0_addr", s_addr, 32'h0000_0300);
    s_ready = 1'b1;
    s_rdata = 32'h3333_4444;
    #1;
    chk("mrst_m0_ready", 32'(m0_ready), 32'd1);
    chk("mrst_m0_rdata", m0_rdata, 32'h3333_4444);
    @(negedge clk);
    s_ready = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("mrst_gap_grant", 32'(grant), 32'd0);
    @(negedge clk);
    #1;
    chk("mrst_m1_next", 32'(grant), 32'd2);
    s_ready = 1'b1;
    #1;
    chk("mrst_m1_done", 32'(m1_ready), 32'd1);
    @(negedge clk);
    s_ready = 1'b0;
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);

    // Stalled slave.
    apply_reset();
    @(negedge clk);
    drive_m(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'b0000);
    s_rdata = 32'h1357_9BDF;
`ifdef MEMARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k < 8) begin
        chk("tmo_wait_ready", 32'(m0_ready), 32'd0);
        chk("tmo_wait_err", 32'(timeout_err), 32'd0);
        chk("tmo_wait_s_valid", 32'(s_valid), 32'd1);
      end else begin
        chk("tmo_ready", 32'(m0_ready), 32'd1);
        chk("tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_s_valid", 32'(s_valid), 32'd0);
      end
    end
    @(negedge clk);
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("tmo_after_grant", 32'(grant), 32'd0);
    chk("tmo_after_err", 32'(timeout_err), 32'd0);
    drive_m(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'b0000);
    @(negedge clk);
    #1;
    chk("tmo_bus_free", 32'(grant), 32'd2);
    s_ready = 1'b1;
    #1;
    chk("tmo_next_ready", 32'(m1_ready), 32'd1);
    @(negedge clk);
    s_ready = 1'b0;
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
`else
    saw_rdy = 0; saw_to = 0; grant_ok = 1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      #1;
      if (m0_ready) saw_rdy = 1;
      if (timeout_err) saw_to = 1;
      if (grant != 2'b01) grant_ok = 0;
    end
    chk("stall_no_ready", 32'(saw_rdy), 32'd0);
    chk("stall_no_timeout", 32'(saw_to), 32'd0);
    chk("stall_grant_held", 32'(grant_ok), 32'd1);
    s_ready = 1'b1;
    s_rdata = 32'h600D_F00D;
    #1;
    chk("late_ready", 32'(m0_ready), 32'd1);
    chk("late_rdata", m0_rdata, 32'h600D_F00D);
    @(negedge clk);
    s_ready = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("late_after_grant", 32'(grant), 32'd0);
`endif

    // Randomized mixed traffic.
    apply_reset();
    run_random(30, 30, 3, 3, g0, g1);
    chk("rnd_m0_count", 32'(g0), 32'd30);
    chk("rnd_m1_count", 32'(g1), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
